// File: rtl/ascon_wb_pkg.sv
// ascon_wb_pkg: register offsets, STATUS/CNTRL bit positions and FSM states for wb_ascon_stream
package ascon_wb_pkg;
   localparam logic [5:0] OFF_STATUS = 6'h00;
   localparam logic [5:0] OFF_CNTRL  = 6'h04;
   localparam logic [5:0] OFF_KEY0   = 6'h08;
   localparam logic [5:0] OFF_NONCE0 = 6'h18;
   localparam logic [5:0] OFF_DIN    = 6'h28;
   localparam logic [5:0] OFF_DOUT   = 6'h2C;
   localparam logic [5:0] OFF_TAG0   = 6'h30;

   localparam int ST_BUSY      = 0;
   localparam int ST_IN_FULL   = 1;
   localparam int ST_IN_EMPTY  = 2;
   localparam int ST_OUT_FULL  = 3;
   localparam int ST_OUT_EMPTY = 4;
   localparam int ST_DONE      = 5;
   localparam int ST_ERR       = 6;

   localparam int CR_START  = 0;
   localparam int CR_MODE   = 1;
   localparam int CR_IRQ_EN = 2;
   localparam int CR_CLR    = 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] sel);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? nw[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/ascon_sync_fifo.sv
// ascon_sync_fifo: single-clock block FIFO; a push and pop in the same cycle both take effect, even when full
module ascon_sync_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic do_push, do_pop;
   assign do_pop = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign rdata = mem[rp];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/wb_ascon_stream.sv
// wb_ascon_stream: Wishbone register front-end that streams 32-bit words into/out of
// CORE_W-bit Ascon core blocks through a pair of block FIFOs
module wb_ascon_stream
   import ascon_wb_pkg::*;
#(
   parameter int CORE_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   output logic              wb_ack_o,
   output logic [31:0]       wb_dat_o,
   output logic [127:0]      key_o,
   output logic [127:0]      nonce_o,
   output logic              mode_o,
   output logic              start_o,
   output logic [CORE_W-1:0] din_o,
   output logic              din_valid_o,
   input  logic              din_ready_i,
   input  logic [CORE_W-1:0] dout_i,
   input  logic              dout_valid_i,
   output logic              dout_ready_o,
   input  logic [127:0]      tag_i,
   input  logic              tag_valid_i,
   output logic              irq_o
);
   localparam logic [1:0] LAST = 2'(CORE_W/32 - 1);
   state_t state, state_n;
   logic mode, irq_en, err, start_n;
   logic [CORE_W-1:0] in_asm, in_blk, out_q;
   logic [1:0] in_cnt, out_cnt, sub;
   logic in_full, in_empty, out_full, out_empty, in_push, in_pop, out_push, out_pop;
   logic [127:0] key, nonce, tag;
   logic [31:0] rd, status;
   logic [5:0] wa;
   logic req, wr, hit, sel_ok, lock, cntrl_wr, start_wr, clr_wr, mode_chg, key_wr, nonce_wr;
   logic din_acc, dout_acc, dout_rd, din_last, dout_ok, err_set;
   assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr = req & wb_we_i;
   assign hit = (wb_adr_i[31:6] == '0) & (wb_adr_i[1:0] == 2'b00);
   assign wa = {wb_adr_i[5:2], 2'b00};
   // KEY and NONCE banks both start at word index 2 mod 4, so one subtract serves both
   assign sub = wb_adr_i[3:2] - 2'd2;
   assign sel_ok = wb_sel_i == 4'hF;
   assign lock = state == S_RUN;
   assign cntrl_wr = wr & hit & (wa == OFF_CNTRL);
   assign start_wr = cntrl_wr & wb_sel_i[0] & wb_dat_i[CR_START];
   assign clr_wr = cntrl_wr & wb_sel_i[0] & wb_dat_i[CR_CLR];
   assign mode_chg = cntrl_wr & wb_sel_i[0] & (wb_dat_i[CR_MODE] != mode);
   assign key_wr = wr & hit & (wa >= OFF_KEY0) & (wa < OFF_NONCE0);
   assign nonce_wr = wr & hit & (wa >= OFF_NONCE0) & (wa < OFF_DIN);
   assign din_acc = req & hit & (wa == OFF_DIN);
   assign dout_acc = req & hit & (wa == OFF_DOUT);
   assign dout_rd = dout_acc & ~wb_we_i;
   assign din_last = din_acc & wb_we_i & sel_ok & (in_cnt == LAST);
   assign dout_ok = dout_rd & sel_ok & ~out_empty;
   assign in_pop = din_valid_o & din_ready_i;
   assign in_push = din_last & (~in_full | in_pop);
   assign out_push = dout_valid_i & dout_ready_o;
   assign out_pop = dout_ok & (out_cnt == LAST);
   assign err_set = ((din_acc | dout_acc) & ~sel_ok) | (din_last & ~in_push) |
                    (dout_rd & sel_ok & out_empty) | (lock & (key_wr | nonce_wr | mode_chg));
   assign key_o = key;
   assign nonce_o = nonce;
   assign mode_o = mode;
   assign din_valid_o = ~in_empty;
   assign dout_ready_o = ~out_full;
   assign irq_o = irq_en & ((state == S_DONE) | err);
   ascon_sync_fifo #(.W(CORE_W), .DEPTH(DEPTH)) u_in_fifo (
      .clk(clk), .rst(RST), .push(in_push), .wdata(in_blk), .pop(in_pop),
      .rdata(din_o), .full(in_full), .empty(in_empty)
   );
   ascon_sync_fifo #(.W(CORE_W), .DEPTH(DEPTH)) u_out_fifo (
      .clk(clk), .rst(RST), .push(out_push), .wdata(dout_i), .pop(out_pop),
      .rdata(out_q), .full(out_full), .empty(out_empty)
   );
   always_comb begin
      in_blk = in_asm;
      in_blk[{in_cnt, 5'd0} +: 32] = wb_dat_i;
   end
   always_comb begin
      status = '0;
      status[ST_BUSY] = state != S_IDLE;
      status[ST_IN_FULL] = in_full;
      status[ST_IN_EMPTY] = in_empty;
      status[ST_OUT_FULL] = out_full;
      status[ST_OUT_EMPTY] = out_empty;
      status[ST_DONE] = state == S_DONE;
      status[ST_ERR] = err;
   end
   always_comb begin
      rd = '0;
      if (hit) begin
         if (wa == OFF_STATUS) rd = status;
         else if (wa == OFF_CNTRL) begin
            rd[CR_MODE] = mode;
            rd[CR_IRQ_EN] = irq_en;
         end
         else if (wa < OFF_NONCE0) rd = key[{sub, 5'd0} +: 32];
         else if (wa < OFF_DIN) rd = nonce[{sub, 5'd0} +: 32];
         else if (wa == OFF_DOUT) rd = dout_ok ? out_q[{out_cnt, 5'd0} +: 32] : '0;
         else if (wa >= OFF_TAG0) rd = tag[{wb_adr_i[3:2], 5'd0} +: 32];
      end
   end
   always_comb begin
      state_n = state;
      start_n = 1'b0;
      if (lock) state_n = tag_valid_i ? S_DONE : S_RUN;
      else if (start_wr) begin
         state_n = S_RUN;
         start_n = 1'b1;
      end
      else if (clr_wr) state_n = S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (RST) begin
         state <= S_IDLE;
         start_o <= 1'b0;
      end else begin
         state <= state_n;
         start_o <= start_n;
      end
   end
   always_ff @(posedge clk) begin
      if (RST) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         key <= '0;
         nonce <= '0;
         tag <= '0;
         mode <= 1'b0;
         irq_en <= 1'b0;
         err <= 1'b0;
         in_asm <= '0;
         in_cnt <= '0;
         out_cnt <= '0;
      end else begin
         wb_ack_o <= req;
         wb_dat_o <= (req & ~wb_we_i) ? rd : '0;
         if (key_wr & ~lock)
            key[{sub, 5'd0} +: 32] <= byte_merge(key[{sub, 5'd0} +: 32], wb_dat_i, wb_sel_i);
         if (nonce_wr & ~lock)
            nonce[{sub, 5'd0} +: 32] <= byte_merge(nonce[{sub, 5'd0} +: 32], wb_dat_i, wb_sel_i);
         if (cntrl_wr & wb_sel_i[0]) begin
            irq_en <= wb_dat_i[CR_IRQ_EN];
            if (~lock) mode <= wb_dat_i[CR_MODE];
         end
         err <= (err & ~clr_wr) | err_set;
         if (lock & tag_valid_i) tag <= tag_i;
         if (din_acc & wb_we_i & sel_ok) begin
            in_asm <= in_blk;
            in_cnt <= din_last ? 2'd0 : in_cnt + 2'd1;
         end
         if (dout_ok) out_cnt <= (out_cnt == LAST) ? 2'd0 : out_cnt + 2'd1;
      end
   end
endmodule

// File: tb/tb_wb_ascon_stream.sv
// tb_wb_ascon_stream: directed vectors; read data and core-side blocks are checked by
// monitors against expected-value queues filled by the stimulus process
module tb_wb_ascon_stream;
   logic clk = 1'b0;
   logic RST = 1'b1;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
   logic [3:0] wb_sel_i = '0;
   logic wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
   logic wb_ack_o;
   logic [31:0] wb_dat_o;
   logic [127:0] key_o, nonce_o;
   logic mode_o, start_o;
   logic [63:0] din_o;
   logic din_valid_o;
   logic din_ready_i = 1'b0;
   logic [63:0] dout_i = '0;
   logic dout_valid_i = 1'b0;
   logic dout_ready_o;
   logic [127:0] tag_i = '0;
   logic tag_valid_i = 1'b0;
   logic irq_o;

   always #5 clk = ~clk;

   wb_ascon_stream #(.CORE_W(64), .DEPTH(4)) dut (
      .clk(clk), .RST(RST),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
      .key_o(key_o), .nonce_o(nonce_o), .mode_o(mode_o), .start_o(start_o),
      .din_o(din_o), .din_valid_o(din_valid_o), .din_ready_i(din_ready_i),
      .dout_i(dout_i), .dout_valid_i(dout_valid_i), .dout_ready_o(dout_ready_o),
      .tag_i(tag_i), .tag_valid_i(tag_valid_i), .irq_o(irq_o)
   );

   int total = 0, passed = 0, start_cnt = 0;
   logic [31:0] rd_q[$];
   string rd_nm[$];
   logic [63:0] din_q[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (start_o) start_cnt++;
      if (wb_ack_o && !wb_we_i) begin
         if (rd_q.size() == 0) begin
            total++;
            $display("FAIL unexpected read ack: got %0h, required no ack", wb_dat_o);
         end else chk(rd_nm.pop_front(), wb_dat_o, rd_q.pop_front());
      end
      if (din_valid_o && din_ready_i) begin
         if (din_q.size() == 0) begin
            total++;
            $display("FAIL unexpected din block: got %0h, required none", din_o);
         end else chk("din block", din_o, din_q.pop_front());
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
      int n;
      n = 0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      do begin
         step();
         n++;
      end while (!wb_ack_o && n < 8);
      chk("ack latency", n, 1);
      step();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
      xfer(1'b1, adr, dat, sel);
   endtask

   task automatic rd(input string nm, input logic [31:0] adr, input logic [31:0] exp,
                     input logic [3:0] sel = 4'hF);
      rd_q.push_back(exp);
      rd_nm.push_back(nm);
      xfer(1'b0, adr, 32'h0, sel);
   endtask

   task automatic din_blk(input logic [63:0] b);
      wr(32'h28, b[31:0]);
      wr(32'h28, b[63:32]);
   endtask

   task automatic core_push(input logic [63:0] b);
      dout_i = b;
      dout_valid_i = 1'b1;
      step();
      dout_valid_i = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) step();
      chk("reset ack", wb_ack_o, 0);
      chk("reset dat", wb_dat_o, 0);
      chk("reset start_o", start_o, 0);
      chk("reset irq", irq_o, 0);
      chk("reset din_valid", din_valid_o, 0);
      chk("reset dout_ready", dout_ready_o, 1);
      RST = 1'b0;
      rd("status after reset", 32'h00, 32'h14);

      wr(32'h08, 32'h0C0D0E0F);
      wr(32'h0C, 32'h08090A0B);
      wr(32'h10, 32'h04050607);
      wr(32'h14, 32'h00010203);
      wr(32'h18, 32'h33221100);
      wr(32'h1C, 32'h77665544);
      wr(32'h20, 32'hBBAA9988);
      wr(32'h24, 32'hFFEEDDCC);
      rd("key word0", 32'h08, 32'h0C0D0E0F);
      chk("key_o", key_o, 128'h000102030405060708090A0B0C0D0E0F);
      chk("nonce_o", nonce_o, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
      wr(32'h0C, 32'hFFFFFFFF, 4'b0001);
      rd("key word1 byte lane", 32'h0C, 32'h08090AFF);
      rd("nonce word2", 32'h20, 32'hBBAA9988);
      rd("unmapped read", 32'h100, 32'h0);

      din_blk(64'h0001020304050607);
      chk("din_valid", din_valid_o, 1);
      chk("din_o", din_o, 64'h0001020304050607);
      wr(32'h04, 32'h4);
      chk("irq with no event", irq_o, 0);
      din_blk(64'h11110000_22220000);
      din_blk(64'h33330000_44440000);
      din_blk(64'h55550000_66660000);
      rd("status fifo full", 32'h00, 32'h12);
      din_blk(64'hDEADBEEF_BAD00005);
      rd("status block dropped", 32'h00, 32'h52);
      chk("irq on err", irq_o, 1);
      rd("cntrl readback", 32'h04, 32'h4);
      din_q.push_back(64'h0001020304050607);
      din_q.push_back(64'h11110000_22220000);
      din_q.push_back(64'h33330000_44440000);
      din_q.push_back(64'h55550000_66660000);
      din_ready_i = 1'b1;
      n = 0;
      while (din_valid_o && n < 20) begin
         step();
         n++;
      end
      din_ready_i = 1'b0;
      chk("din drained", din_valid_o, 0);
      chk("din blocks left", din_q.size(), 0);
      rd("status drained", 32'h00, 32'h54);
      wr(32'h04, 32'h8);
      rd("status after clr", 32'h00, 32'h14);
      chk("irq after clr", irq_o, 0);

      wr(32'h04, 32'h1);
      rd("status run", 32'h00, 32'h15);
      chk("start pulses", start_cnt, 1);
      wr(32'h04, 32'h1);
      rd("start in run no err", 32'h00, 32'h15);
      wr(32'h08, 32'hDEADBEEF);
      rd("key locked in run", 32'h08, 32'h0C0D0E0F);
      wr(32'h04, 32'h2);
      chk("mode locked in run", mode_o, 0);
      core_push(64'hAAAA5555_1234ABCD);
      tag_i = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      tag_valid_i = 1'b1;
      step();
      tag_valid_i = 1'b0;
      rd("status done", 32'h00, 32'h65);
      rd("dout word0", 32'h2C, 32'h1234ABCD);
      rd("dout word1", 32'h2C, 32'hAAAA5555);
      rd("tag word0", 32'h30, 32'hCCDDEEFF);
      rd("tag word1", 32'h34, 32'h8899AABB);
      rd("tag word3", 32'h3C, 32'h00112233);
      chk("start pulses run", start_cnt, 1);

      rd("dout empty", 32'h2C, 32'h0);
      rd("status empty read", 32'h00, 32'h75);
      wr(32'h04, 32'h8);
      rd("status clr to idle", 32'h00, 32'h14);
      core_push(64'h11112222_33334444);
      rd("dout after empty word0", 32'h2C, 32'h33334444);
      rd("dout after empty word1", 32'h2C, 32'h11112222);
      wr(32'h28, 32'h12345678, 4'h3);
      rd("status din bad sel", 32'h00, 32'h54);
      wr(32'h04, 32'h8);

      din_blk(64'h77777777_88888888);
      din_blk(64'h99999999_AAAAAAAA);
      wr(32'h04, 32'h1);
      core_push(64'hBBBBBBBB_CCCCCCCC);
      chk("start pulses second", start_cnt, 2);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst din_valid", din_valid_o, 0);
      chk("rst dout_ready", dout_ready_o, 1);
      chk("rst start_o", start_o, 0);
      chk("rst irq", irq_o, 0);
      rd("status after rst in run", 32'h00, 32'h14);
      chk("read queue drained", rd_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
